// File: rtl/mem_port_arbiter.sv
// Arbitrates the data memory's single read/write port between requester 0 (LSU) and requester 1 (DMA).
// Round-robin ownership FSM with a burst limit. Define ARB_STATS_EN to build the grant/wait counters.
module mem_port_arbiter #(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wd0,
  output logic          gnt0,
  output logic          rvalid0,
  output logic [DW-1:0] rdata0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wd1,
  output logic          gnt1,
  output logic          rvalid1,
  output logic [DW-1:0] rdata1,
  output logic          mem_we,
  output logic [AW-1:0] mem_rwa,
  output logic [DW-1:0] mem_wd,
  input  logic [DW-1:0] mem_rwd,
  output logic [1:0]    owner,
  output logic [15:0]   gnt_cnt0,
  output logic [15:0]   gnt_cnt1,
  output logic [15:0]   wait_cnt
);

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_OWN0 = 2'b01;
  localparam logic [1:0] ST_OWN1 = 2'b10;

  localparam int          CW          = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] BURST_SAT = CW'(MAX_BURST);
  localparam logic [31:0]   BURST_LIM = MAX_BURST;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] burst_cnt_q, burst_cnt_d;
  logic          rr_ptr_q, rr_ptr_d;
  logic          rvalid0_q, rvalid0_d;
  logic          rvalid1_q, rvalid1_d;
  logic [DW-1:0] rdata0_q, rdata0_d;
  logic [DW-1:0] rdata1_q, rdata1_d;

  logic gnt_any;
  logic burst_hit;

  // Port mux and grants follow the registered owner only, so a requester sees
  // its grant in the same cycle it holds req while owning the port.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    mem_we  = 1'b0;
    mem_rwa = '0;
    mem_wd  = '0;
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    case (state_q)
      ST_OWN0: begin
        mem_rwa = addr0;
        mem_wd  = wd0;
        mem_we  = we0 & req0;
        gnt0    = req0;
      end
      ST_OWN1: begin
        mem_rwa = addr1;
        mem_wd  = wd1;
        mem_we  = we1 & req1;
        gnt1    = req1;
      end
      default: ;
    endcase
  end

  assign gnt_any   = gnt0 | gnt1;
  assign burst_hit = (32'(burst_cnt_q) + 32'(gnt_any)) >= BURST_LIM;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (req0 && req1)  state_d = rr_ptr_q ? ST_OWN1 : ST_OWN0;
        else if (req0)     state_d = ST_OWN0;
        else if (req1)     state_d = ST_OWN1;
        else               state_d = ST_IDLE;
      end
      ST_OWN0: begin
        if (req1 && (!req0 || burst_hit)) state_d = ST_OWN1;
        else if (req0)                    state_d = ST_OWN0;
        else                              state_d = ST_IDLE;
      end
      ST_OWN1: begin
        if (req0 && (!req1 || burst_hit)) state_d = ST_OWN0;
        else if (req1)                    state_d = ST_OWN1;
        else                              state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Burst count restarts on every ownership change; rr_ptr favours the requester that just lost out.
  always_comb begin
    burst_cnt_d = burst_cnt_q;
    rr_ptr_d    = rr_ptr_q;
    if (state_d != state_q || state_d == ST_IDLE) begin
      burst_cnt_d = '0;
    end else if (gnt_any && burst_cnt_q < BURST_SAT) begin
      burst_cnt_d = burst_cnt_q + CW'(1);
    end
    if (state_d == ST_OWN0 && state_q != ST_OWN0) rr_ptr_d = 1'b1;
    if (state_d == ST_OWN1 && state_q != ST_OWN1) rr_ptr_d = 1'b0;
  end

  always_comb begin
    rvalid0_d = gnt0 & ~we0;
    rvalid1_d = gnt1 & ~we1;
    rdata0_d  = rvalid0_d ? mem_rwd : rdata0_q;
    rdata1_d  = rvalid1_d ? mem_rwd : rdata1_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      burst_cnt_q <= '0;
      rr_ptr_q    <= 1'b0;
      rvalid0_q   <= 1'b0;
      rvalid1_q   <= 1'b0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      state_q     <= state_d;
      burst_cnt_q <= burst_cnt_d;
      rr_ptr_q    <= rr_ptr_d;
      rvalid0_q   <= rvalid0_d;
      rvalid1_q   <= rvalid1_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
    end
  end

  assign rvalid0 = rvalid0_q;
  assign rvalid1 = rvalid1_q;
  assign rdata0  = rdata0_q;
  assign rdata1  = rdata1_q;
  assign owner   = state_q;

`ifdef ARB_STATS_EN
  logic [15:0] gnt_cnt0_q, gnt_cnt0_d;
  logic [15:0] gnt_cnt1_q, gnt_cnt1_d;
  logic [15:0] wait_cnt_q, wait_cnt_d;
  logic        wait_any;

  assign wait_any = (req0 & ~gnt0) | (req1 & ~gnt1);

  // All counters saturate rather than wrap.
  always_comb begin
    gnt_cnt0_d = gnt_cnt0_q;
    gnt_cnt1_d = gnt_cnt1_q;
    wait_cnt_d = wait_cnt_q;
    if (gnt0 && gnt_cnt0_q != 16'hFFFF)     gnt_cnt0_d = gnt_cnt0_q + 16'd1;
    if (gnt1 && gnt_cnt1_q != 16'hFFFF)     gnt_cnt1_d = gnt_cnt1_q + 16'd1;
    if (wait_any && wait_cnt_q != 16'hFFFF) wait_cnt_d = wait_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_cnt0_q <= '0;
      gnt_cnt1_q <= '0;
      wait_cnt_q <= '0;
    end else begin
      gnt_cnt0_q <= gnt_cnt0_d;
      gnt_cnt1_q <= gnt_cnt1_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign gnt_cnt0 = gnt_cnt0_q;
  assign gnt_cnt1 = gnt_cnt1_q;
  assign wait_cnt = wait_cnt_q;
`else
  assign gnt_cnt0 = '0;
  assign gnt_cnt1 = '0;
  assign wait_cnt = '0;
`endif

endmodule
